instruction_axi_read_bridge: RTL and testbench
==============================================

# instruction_axi_read_bridge

Converts the CPU core's instruction-side SRAM-like request/ready handshake into AXI3 read transactions. Sits directly upstream of the fetch stage: it drives the instruction_ram_address_ready, instruction_ram_data_ready and instruction_ram_read_data inputs of the fetch stage and owns the AR/R channels toward the AXI crossbar. Supports up to MAX_OUTSTANDING in-order single-beat reads, so the fetch stage can issue its next address in the cycle the previous data returns.

## Interface
- MAX_OUTSTANDING, 2, maximum reads in flight, counting a pending AR plus ARs awaiting R; legal 1..7
- AXI_ID, 4'h0, constant ARID value
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state immediately
- instruction_ram_request  in  1  fetch requests a read this cycle
- instruction_ram_size  in  2  log2 bytes; fetch always drives 2'b10
- instruction_ram_address  in  32  physical byte address
- instruction_ram_address_ready  out  1  request accepted this cycle when high with request
- instruction_ram_data_ready  out  1  read data valid this cycle; one pulse per accepted request, in order
- instruction_ram_read_data  out  32  read data, valid with data_ready
- instruction_ram_bus_error  out  1  high with data_ready when RRESP != 2'b00
- arid 4, araddr 32, arlen 8, arsize 3, arburst 2, arlock 2, arcache 4, arprot 3, arvalid 1 (all out); arready 1 (in)
- rid 4, rdata 32, rresp 2, rlast 1, rvalid 1 (all in); rready 1 (out)

## Operation
- AR register: ar_valid, ar_address, ar_size. On accept (request && address_ready), load ar_address <= address and ar_size <= size, and set ar_valid. Clear ar_valid on arready && !accept.
- Constant outputs: arid=AXI_ID, arlen=0, arburst=2'b01, arlock=0, arcache=0, arprot=0. arsize={1'b0, ar_size}.
- outstanding counter, width $clog2(MAX_OUTSTANDING+1): +1 on AR handshake (arvalid && arready), -1 on R handshake (rvalid && rready). Both in the same cycle leave it unchanged.
- in_flight = outstanding + ar_valid.
- address_ready = !reset && (!ar_valid || arready) && (in_flight < MAX_OUTSTANDING || (rvalid && rready)).
- rready = (outstanding != 0). Only AR-completed reads may consume R.
- data_ready = rvalid && rready. read_data = rdata combinationally. bus_error = data_ready && (rresp != 0).
- rid and rlast are ignored; the crossbar guarantees in-order, single-beat responses for one ID.
- A write request never arrives on this port. There is no write channel.
- Request-side flushes are the fetch stage's concern. Every accepted request produces exactly one data_ready.

## Timing
- Reset values: arvalid=0, araddr=0, arsize=0, rready=0, data_ready=0, bus_error=0, address_ready=0 while reset is high and 1 in the first cycle after release.
- Accept in cycle N gives arvalid=1 in N+1 with the latched address. The fastest data_ready is N+2, when arready is high at N+1 and rvalid is high at N+2.
- Back-to-back: an accept in the cycle of the AR handshake reloads the AR register, so arvalid stays high with the new address.
- Full: when in_flight == MAX_OUTSTANDING, address_ready=0 unless an R handshake occurs that cycle. A simultaneous R completion and new accept keeps in_flight constant.
- arvalid stays asserted and araddr/arsize stay stable until arready, per AXI.
- Counter never wraps. Overflow and underflow are impossible by construction; an assertion checks this.
- Reset mid-transaction drops all state. The interconnect is reset by the same signal.

## Test plan
- Single fetch to 0x1fc00000: arvalid and araddr=0x1fc00000, arsize=3'b010, arlen=0 one cycle after accept. rvalid with rdata=0x3c1a0000 gives data_ready=1 and read_data=0x3c1a0000 the same cycle.
- arready held low 5 cycles: araddr stays stable and address_ready=0 throughout. Exactly one data_ready follows.
- Request held high with arready=1 and rvalid delayed: two ARs are issued (0x0, 0x4), then address_ready=0. On the first R, a third accept happens the same cycle. Data returns in order.
- rresp=2'b10 on one beat: bus_error=1 only in that data_ready cycle.
- Reset asserted with 2 in flight and arvalid=1: arvalid, rready and data_ready drop asynchronously. After release, address_ready=1 and the counter is 0.
- Random arready/rvalid stalls over 10k requests: request and response counts match, order is preserved, and in_flight never exceeds MAX_OUTSTANDING.

Source files
------------

// File: rtl/instruction_axi_read_bridge_if.sv
// AXI3 read-address and read-data channels between the instruction bridge
// (master) and the AXI crossbar (slave).
interface instruction_axi_read_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/instruction_axi_read_bridge.sv
// Instruction-fetch SRAM-like handshake to AXI3 single-beat reads.
// Up to MAX_OUTSTANDING reads in flight, returned strictly in order.
module instruction_axi_read_bridge #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [3:0]  AXI_ID          = 4'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instruction_ram_request,
  input  logic [1:0]  instruction_ram_size,
  input  logic [31:0] instruction_ram_address,
  output logic        instruction_ram_address_ready,
  output logic        instruction_ram_data_ready,
  output logic [31:0] instruction_ram_read_data,
  output logic        instruction_ram_bus_error,
  instruction_axi_read_bridge_if.master axi
);

  localparam int unsigned CountWidth    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned InFlightWidth = CountWidth + 1;
  localparam logic [CountWidth-1:0]    MaxCount    = CountWidth'(MAX_OUTSTANDING);
  localparam logic [InFlightWidth-1:0] MaxInFlight = InFlightWidth'(MAX_OUTSTANDING);

  logic                     ar_valid_q, ar_valid_d;
  logic [31:0]              ar_address_q, ar_address_d;
  logic [1:0]               ar_size_q, ar_size_d;
  logic [CountWidth-1:0]    outstanding_q, outstanding_d;
  logic [InFlightWidth-1:0] in_flight;
  logic                     ar_handshake;
  logic                     r_handshake;
  logic                     accept;

  // rid/rlast carry no information for in-order single-beat traffic.
  logic unused_resp_fields;
  assign unused_resp_fields = ^{axi.rid, axi.rlast};

  // Handshake decode and fetch-side outputs.
  always_comb begin
    ar_handshake = ar_valid_q && axi.arready;
    axi.rready   = (outstanding_q != '0);
    r_handshake  = axi.rvalid && axi.rready;
    in_flight    = {1'b0, outstanding_q} + InFlightWidth'(ar_valid_q);
    // A returning beat frees a slot in the same cycle, so the fetch stage can
    // issue its next address while the previous data is delivered.
    instruction_ram_address_ready = !reset && (!ar_valid_q || axi.arready) &&
                                    ((in_flight < MaxInFlight) || r_handshake);
    accept                        = instruction_ram_request && instruction_ram_address_ready;
    instruction_ram_data_ready    = r_handshake;
    instruction_ram_read_data     = axi.rdata;
    instruction_ram_bus_error     = r_handshake && (axi.rresp != 2'b00);
  end

  // Fixed AR attributes: single-beat INCR, normal access.
  always_comb begin
    axi.arid    = AXI_ID;
    axi.araddr  = ar_address_q;
    axi.arlen   = 8'd0;
    axi.arsize  = {1'b0, ar_size_q};
    axi.arburst = 2'b01;
    axi.arlock  = 2'b00;
    axi.arcache = 4'b0000;
    axi.arprot  = 3'b000;
    axi.arvalid = ar_valid_q;
  end

  // Next state for the AR holding register and outstanding counter.
  always_comb begin
    ar_valid_d    = ar_valid_q;
    ar_address_d  = ar_address_q;
    ar_size_d     = ar_size_q;
    outstanding_d = outstanding_q;
    // Accept is only possible when the register is empty or draining this
    // cycle, so reloading never drops an un-handshaken AR.
    if (accept) begin
      ar_valid_d   = 1'b1;
      ar_address_d = instruction_ram_address;
      ar_size_d    = instruction_ram_size;
    end else if (axi.arready) begin
      ar_valid_d = 1'b0;
    end
    unique case ({ar_handshake, r_handshake})
      2'b10:   outstanding_d = outstanding_q + CountWidth'(1);
      2'b01:   outstanding_d = outstanding_q - CountWidth'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers, cleared immediately by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ar_valid_q    <= 1'b0;
      ar_address_q  <= 32'd0;
      ar_size_q     <= 2'b00;
      outstanding_q <= '0;
    end else begin
      ar_valid_q    <= ar_valid_d;
      ar_address_q  <= ar_address_d;
      ar_size_q     <= ar_size_d;
      outstanding_q <= outstanding_d;
    end
  end

  // Counter must never wrap in either direction.
  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (in_flight <= MaxInFlight);
      assert (!(r_handshake && (outstanding_q == '0)));
      assert (!(ar_handshake && !r_handshake && (outstanding_q == MaxCount)));
    end
  end

endmodule

// File: tb/tb_instruction_axi_read_bridge.sv
module tb_instruction_axi_read_bridge;
  localparam int unsigned MaxOut = 2;
  localparam int          NumRandom = 10000;
  localparam int          RandomBudget = 80000;

  logic        clock;
  logic        reset;
  logic        req;
  logic [1:0]  size;
  logic [31:0] addr;
  logic        addr_ready;
  logic        data_ready;
  logic [31:0] read_data;
  logic        bus_error;

  int          total;
  int          bad;
  logic [31:0] exp_q[$];

  instruction_axi_read_bridge_if axi ();

  instruction_axi_read_bridge #(
    .MAX_OUTSTANDING(MaxOut),
    .AXI_ID         (4'h0)
  ) dut (
    .clock                        (clock),
    .reset                        (reset),
    .instruction_ram_request      (req),
    .instruction_ram_size         (size),
    .instruction_ram_address      (addr),
    .instruction_ram_address_ready(addr_ready),
    .instruction_ram_data_ready   (data_ready),
    .instruction_ram_read_data    (read_data),
    .instruction_ram_bus_error    (bus_error),
    .axi                          (axi)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'ha5a5_5a5a;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    req = 1'b0; size = 2'b10; addr = 32'd0;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = 32'd0; axi.rresp = 2'b00;
    axi.rid = 4'd0; axi.rlast = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    tick(); tick();
    req = 1'b1; axi.rvalid = 1'b1;
    #1;
    total++; if (addr_ready !== 1'b0) begin bad++; $display("FAIL rst_ardy: got %b want 0", addr_ready); end
    total++; if (axi.arvalid !== 1'b0) begin bad++; $display("FAIL rst_arvalid: got %b want 0", axi.arvalid); end
    total++; if (axi.araddr !== 32'd0) begin bad++; $display("FAIL rst_araddr: got %h want 0", axi.araddr); end
    total++; if (axi.arsize !== 3'd0) begin bad++; $display("FAIL rst_arsize: got %b want 0", axi.arsize); end
    total++; if (axi.rready !== 1'b0) begin bad++; $display("FAIL rst_rready: got %b want 0", axi.rready); end
    total++; if (data_ready !== 1'b0) begin bad++; $display("FAIL rst_dready: got %b want 0", data_ready); end
    total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL rst_berr: got %b want 0", bus_error); end
    req = 1'b0; axi.rvalid = 1'b0; reset = 1'b0;
    #1;
    total++; if (addr_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ardy: got %b want 1", addr_ready); end
    tick();
  endtask

  task automatic test_single();
    logic [31:0] e;
    idle();
    req = 1'b1; addr = 32'h1fc0_0000;
    #1;
    total++; if (addr_ready !== 1'b1) begin bad++; $display("FAIL single_ardy: got %b want 1", addr_ready); end
    if (req && addr_ready) exp_q.push_back(32'h3c1a_0000);
    tick();
    req = 1'b0; axi.arready = 1'b1;
    #1;
    total++; if (axi.arvalid !== 1'b1) begin bad++; $display("FAIL single_arvalid: got %b want 1", axi.arvalid); end
    total++; if (axi.araddr !== 32'h1fc0_0000) begin bad++; $display("FAIL single_araddr: got %h want 1fc00000", axi.araddr); end
    total++; if (axi.arsize !== 3'b010) begin bad++; $display("FAIL single_arsize: got %b want 010", axi.arsize); end
    total++; if (axi.arlen !== 8'd0) begin bad++; $display("FAIL single_arlen: got %h want 0", axi.arlen); end
    total++; if (axi.arburst !== 2'b01) begin bad++; $display("FAIL single_arburst: got %b want 01", axi.arburst); end
    total++; if (axi.arid !== 4'h0) begin bad++; $display("FAIL single_arid: got %h want 0", axi.arid); end
    total++; if (axi.rready !== 1'b0) begin bad++; $display("FAIL single_rready_early: got %b want 0", axi.rready); end
    tick();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = 32'h3c1a_0000;
    #1;
    total++; if (axi.arvalid !== 1'b0) begin bad++; $display("FAIL single_arvalid_drop: got %b want 0", axi.arvalid); end
    total++; if (axi.rready !== 1'b1) begin bad++; $display("FAIL single_rready: got %b want 1", axi.rready); end
    total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL single_berr: got %b want 0", bus_error); end
    total++;
    if (data_ready !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL single_data: data_ready=%b pending=%0d want 1 and 1", data_ready, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (read_data !== e) begin bad++; $display("FAIL single_data: got %h want %h", read_data, e); end
    end
    tick();
    axi.rvalid = 1'b0;
    #1;
    total++; if (axi.rready !== 1'b0) begin bad++; $display("FAIL single_rready_idle: got %b want 0", axi.rready); end
    tick();
  endtask

  task automatic test_ar_stall();
    logic [31:0] e;
    int          extra;
    idle();
    req = 1'b1; addr = 32'h0000_0100;
    #1;
    total++; if (addr_ready !== 1'b1) begin bad++; $display("FAIL stall_ardy0: got %b want 1", addr_ready); end
    if (req && addr_ready) exp_q.push_back(mem_word(32'h100));
    tick();
    addr = 32'h0000_0104;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h100 || addr_ready !== 1'b0) begin
        bad++;
        $display("FAIL stall_hold%0d: arvalid=%b araddr=%h ardy=%b want 1 00000100 0",
                 i, axi.arvalid, axi.araddr, addr_ready);
      end
      tick();
    end
    req = 1'b0; axi.arready = 1'b1;
    #1;
    total++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h100) begin
      bad++; $display("FAIL stall_release: arvalid=%b araddr=%h want 1 00000100", axi.arvalid, axi.araddr);
    end
    tick();
    axi.arready = 1'b0; axi.rvalid = 1'b1; axi.rdata = mem_word(32'h100);
    #1;
    total++;
    if (data_ready !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL stall_data: data_ready=%b pending=%0d want 1 and 1", data_ready, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (read_data !== e) begin bad++; $display("FAIL stall_data: got %h want %h", read_data, e); end
    end
    tick();
    axi.rvalid = 1'b0;
    extra = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (data_ready === 1'b1) extra++;
      tick();
    end
    total++; if (extra != 0) begin bad++; $display("FAIL stall_extra: got %0d extra pulses want 0", extra); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    idle();
    axi.arready = 1'b1; req = 1'b1; addr = 32'h0;
    #1;
    total++; if (addr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ardy0: got %b want 1", addr_ready); end
    if (req && addr_ready) exp_q.push_back(mem_word(addr));
    tick();
    addr = 32'h4;
    #1;
    total++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h0 || addr_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_c1: arvalid=%b araddr=%h ardy=%b want 1 00000000 1", axi.arvalid, axi.araddr, addr_ready);
    end
    if (req && addr_ready) exp_q.push_back(mem_word(addr));
    tick();
    addr = 32'h8;
    #1;
    total++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h4 || addr_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_full: arvalid=%b araddr=%h ardy=%b want 1 00000004 0", axi.arvalid, axi.araddr, addr_ready);
    end
    tick();
    #1;
    total++; if (axi.arvalid !== 1'b0 || addr_ready !== 1'b0 || axi.rready !== 1'b1) begin
      bad++; $display("FAIL b2b_wait: arvalid=%b ardy=%b rready=%b want 0 0 1", axi.arvalid, addr_ready, axi.rready);
    end
    tick();
    axi.rvalid = 1'b1; axi.rdata = mem_word(32'h0);
    #1;
    total++; if (addr_ready !== 1'b1) begin bad++; $display("FAIL b2b_refill_ardy: got %b want 1", addr_ready); end
    total++;
    if (data_ready !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL b2b_data0: data_ready=%b pending=%0d want 1 and 1", data_ready, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (read_data !== e) begin bad++; $display("FAIL b2b_data0: got %h want %h", read_data, e); end
    end
    if (req && addr_ready) exp_q.push_back(mem_word(addr));
    tick();
    req = 1'b0; axi.rdata = mem_word(32'h4);
    #1;
    total++; if (axi.arvalid !== 1'b1 || axi.araddr !== 32'h8) begin
      bad++; $display("FAIL b2b_third_ar: arvalid=%b araddr=%h want 1 00000008", axi.arvalid, axi.araddr);
    end
    total++;
    if (data_ready !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL b2b_data1: data_ready=%b pending=%0d want 1 and 1", data_ready, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (read_data !== e) begin bad++; $display("FAIL b2b_data1: got %h want %h", read_data, e); end
    end
    tick();
    axi.rdata = mem_word(32'h8);
    #1;
    total++;
    if (data_ready !== 1'b1 || exp_q.size() == 0) begin
      bad++; $display("FAIL b2b_data2: data_ready=%b pending=%0d want 1 and 1", data_ready, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (read_data !== e) begin bad++; $display("FAIL b2b_data2: got %h want %h", read_data, e); end
    end
    tick();
    axi.rvalid = 1'b0; axi.arready = 1'b0;
    #1;
    total++; if (axi.rready !== 1'b0) begin bad++; $display("FAIL b2b_drained: rready=%b want 0", axi.rready); end
    tick();
  endtask

  task automatic test_bus_error();
    idle();
    req = 1'b1; addr = 32'h200;
    #1;
    tick();
    addr = 32'h204; axi.arready = 1'b1;
    #1;
    total++; if (addr_ready !== 1'b1) begin bad++; $display("FAIL berr_ardy: got %b want 1", addr_ready); end
    tick();
    req = 1'b0; axi.rvalid = 1'b1; axi.rdata = mem_word(32'h200); axi.rresp = 2'b10;
    #1;
    total++; if (data_ready !== 1'b1 || bus_error !== 1'b1) begin
      bad++; $display("FAIL berr_set: data_ready=%b bus_error=%b want 1 1", data_ready, bus_error);
    end
    tick();
    axi.arready = 1'b0; axi.rdata = mem_word(32'h204); axi.rresp = 2'b00;
    #1;
    total++; if (data_ready !== 1'b1 || bus_error !== 1'b0) begin
      bad++; $display("FAIL berr_okay: data_ready=%b bus_error=%b want 1 0", data_ready, bus_error);
    end
    tick();
    axi.rvalid = 1'b0; axi.rresp = 2'b10;
    #1;
    total++; if (bus_error !== 1'b0) begin bad++; $display("FAIL berr_idle: got %b want 0", bus_error); end
    axi.rresp = 2'b00;
    tick();
  endtask

  task automatic test_reset_midflight();
    idle();
    req = 1'b1; addr = 32'h300;
    #1;
    tick();
    axi.arready = 1'b1; addr = 32'h304;
    #1;
    total++; if (addr_ready !== 1'b1) begin bad++; $display("FAIL mid_ardy: got %b want 1", addr_ready); end
    tick();
    req = 1'b0; axi.arready = 1'b0;
    #1;
    total++; if (axi.arvalid !== 1'b1 || axi.rready !== 1'b1) begin
      bad++; $display("FAIL mid_pre: arvalid=%b rready=%b want 1 1", axi.arvalid, axi.rready);
    end
    axi.rvalid = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    total++; if (axi.arvalid !== 1'b0 || axi.rready !== 1'b0 || data_ready !== 1'b0 || addr_ready !== 1'b0) begin
      bad++; $display("FAIL mid_async: arvalid=%b rready=%b dready=%b ardy=%b want 0 0 0 0",
                      axi.arvalid, axi.rready, data_ready, addr_ready);
    end
    exp_q.delete();
    tick();
    axi.rvalid = 1'b0; reset = 1'b0;
    #1;
    total++; if (addr_ready !== 1'b1 || axi.arvalid !== 1'b0) begin
      bad++; $display("FAIL mid_release: ardy=%b arvalid=%b want 1 0", addr_ready, axi.arvalid);
    end
    axi.rvalid = 1'b1;
    #1;
    total++; if (axi.rready !== 1'b0 || data_ready !== 1'b0) begin
      bad++; $display("FAIL mid_counter: rready=%b dready=%b want 0 0", axi.rready, data_ready);
    end
    axi.rvalid = 1'b0;
    tick();
  endtask

  task automatic test_random_stalls();
    logic [31:0] slave_q[$];
    logic [31:0] e;
    logic [31:0] next_addr;
    logic [31:0] prev_addr;
    logic        prev_stall;
    logic        r_pend;
    int          acc;
    int          ret;
    int          cycles;
    idle();
    exp_q.delete();
    next_addr = 32'h1fc0_0000;
    prev_stall = 1'b0; prev_addr = 32'd0; r_pend = 1'b0;
    acc = 0; ret = 0; cycles = 0;
    while ((acc < NumRandom || ret < NumRandom) && cycles < RandomBudget) begin
      req = (acc < NumRandom) && ($urandom_range(7) != 0);
      addr = next_addr;
      axi.arready = ($urandom_range(2) != 0);
      if (!r_pend) begin
        if (slave_q.size() > 0 && $urandom_range(2) != 0) begin
          axi.rvalid = 1'b1;
          axi.rdata = mem_word(slave_q[0]);
          axi.rresp = ($urandom_range(15) == 0) ? 2'b10 : 2'b00;
        end else begin
          axi.rvalid = 1'b0;
          axi.rdata = $urandom;
          axi.rresp = 2'b00;
        end
      end
      #1;
      if (prev_stall) begin
        total++;
        if (axi.arvalid !== 1'b1 || axi.araddr !== prev_addr) begin
          bad++; $display("FAIL rnd_ar_stable: arvalid=%b araddr=%h want 1 %h", axi.arvalid, axi.araddr, prev_addr);
        end
      end
      prev_stall = axi.arvalid && !axi.arready;
      prev_addr = axi.araddr;
      total++;
      if (data_ready !== axi.rvalid) begin
        bad++; $display("FAIL rnd_dready: got %b want %b", data_ready, axi.rvalid);
      end
      if (data_ready === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_data: data_ready with nothing outstanding");
        end else begin
          e = exp_q.pop_front();
          if (read_data !== e || bus_error !== (axi.rresp != 2'b00)) begin
            bad++; $display("FAIL rnd_data: got %h err=%b want %h err=%b", read_data, bus_error, e, axi.rresp != 2'b00);
          end
        end
        ret++;
      end
      if (req && addr_ready) begin
        exp_q.push_back(mem_word(addr));
        acc++;
        next_addr = next_addr + 32'd4;
      end
      if (axi.arvalid && axi.arready) slave_q.push_back(axi.araddr);
      if (axi.rvalid && axi.rready && slave_q.size() > 0) slave_q.pop_front();
      r_pend = axi.rvalid && !axi.rready;
      total++;
      if (acc - ret > int'(MaxOut)) begin
        bad++; $display("FAIL rnd_in_flight: got %0d want <= %0d", acc - ret, MaxOut);
      end
      tick();
      cycles++;
    end
    total++;
    if (acc != NumRandom || ret != NumRandom) begin
      bad++; $display("FAIL rnd_timeout: accepted=%0d returned=%0d want %0d each", acc, ret, NumRandom);
    end
    idle();
    tick();
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_single();
    test_ar_stall();
    test_back_to_back();
    test_bus_error();
    test_reset_midflight();
    test_random_stalls();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
